// File: rtl/rom_port_arbiter.sv
// Arbitrates the single-port instruction ROM between the fetch port (I) and the data-load port (D).
// D wins ties until it has starved I for MAX_D_STREAK cycles in a row. Bad D addresses get an error response.
module rom_port_arbiter #(
  parameter int DEPTH        = 512,
  parameter int DEPTH_LOG    = 9,
  parameter int WIDTH        = 32,
  parameter int MAX_D_STREAK = 3
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic [WIDTH-1:0]     i_rdata,
  input  logic                 d_req,
  input  logic [31:0]          d_addr,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [WIDTH-1:0]     d_rdata,
  output logic                 d_err,
  output logic [DEPTH_LOG-1:0] rom_addr,
  input  logic [WIDTH-1:0]     rom_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] StreakMax = SW'(MAX_D_STREAK);

  logic [DEPTH_LOG-1:0] iIdx;
  logic [DEPTH_LOG-1:0] dIdx;
  logic [DEPTH_LOG-1:0] lastAddr;
  logic [SW-1:0]        streak;
  logic [SW-1:0]        streakNext;
  logic                 dBad;
  logic                 grantI;
  logic                 grantD;
  logic                 grantBad;
  logic                 iValid;
  logic                 dValid;
  logic                 dErr;
  logic                 unusedAddrBits;

  assign iIdx = i_addr[DEPTH_LOG+1:2];
  assign dIdx = d_addr[DEPTH_LOG+1:2];
  assign unusedAddrBits = ^{i_addr[31:DEPTH_LOG+2], i_addr[1:0]};

  // A D address outside the ROM or not word-aligned is answered with an error and never touches the ROM.
  assign dBad = (d_addr[1:0] != 2'b00) || (d_addr[31:2] >= 30'(DEPTH));

  always_comb begin
    grantD     = 1'b0;
    grantI     = 1'b0;
    grantBad   = 1'b0;
    streakNext = streak;
    if (resetb) begin
      grantBad = d_req && dBad;
      grantD   = d_req && !dBad && (!i_req || (streak != StreakMax));
      grantI   = i_req && !grantD;
      if (!i_req || grantI) begin
        streakNext = '0;
      end else if (grantD && (streak != StreakMax)) begin
        streakNext = streak + 1'b1;
      end
    end
  end

  assign i_gnt = grantI;
  assign d_gnt = grantD || grantBad;

  always_comb begin
    rom_addr = lastAddr;
    if (!resetb) begin
      rom_addr = '0;
    end else if (grantD) begin
      rom_addr = dIdx;
    end else if (grantI) begin
      rom_addr = iIdx;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      streak   <= '0;
      lastAddr <= '0;
      iValid   <= 1'b0;
      dValid   <= 1'b0;
      dErr     <= 1'b0;
    end else begin
      streak   <= streakNext;
      iValid   <= grantI;
      dValid   <= grantD || grantBad;
      dErr     <= grantBad;
      if (grantD || grantI) begin
        lastAddr <= rom_addr;
      end
    end
  end

  // The ROM's registered output is shared; each port only sees it while its own good response is valid.
  assign i_rvalid = iValid;
  assign i_rdata  = iValid ? rom_rdata : '0;
  assign d_rvalid = dValid;
  assign d_err    = dErr;
  assign d_rdata  = (dValid && !dErr) ? rom_rdata : '0;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter; a behavioural ROM returns 32'hC0DE0000 | word index.
module tb_rom_port_arbiter;

  logic        clk;
  logic        resetb;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [8:0]  rom_addr;
  logic [31:0] rom_rdata;

  int checks = 0;
  int errors = 0;

  rom_port_arbiter #(
    .DEPTH(512), .DEPTH_LOG(9), .WIDTH(32), .MAX_D_STREAK(3)
  ) dut (
    .clk(clk), .resetb(resetb),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err), .rom_addr(rom_addr), .rom_rdata(rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROM model
  always @(posedge clk) rom_rdata <= 32'hC0DE0000 | {23'd0, rom_addr};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
    @(negedge clk);
    i_req  = ir;
    i_addr = ia;
    d_req  = dr;
    d_addr = da;
    #1;
  endtask

  task automatic expGnt(input string tag, input logic ig, input logic dg, input logic [8:0] ra);
    checkOutput({tag, ".i_gnt"}, {31'd0, i_gnt}, {31'd0, ig});
    checkOutput({tag, ".d_gnt"}, {31'd0, d_gnt}, {31'd0, dg});
    checkOutput({tag, ".rom_addr"}, {23'd0, rom_addr}, {23'd0, ra});
  endtask

  task automatic tickAndRsp(input string tag, input logic iv, input logic [31:0] ird,
                            input logic dv, input logic de, input logic [31:0] drd);
    @(posedge clk);
    #1;
    checkOutput({tag, ".i_rvalid"}, {31'd0, i_rvalid}, {31'd0, iv});
    checkOutput({tag, ".i_rdata"}, i_rdata, ird);
    checkOutput({tag, ".d_rvalid"}, {31'd0, d_rvalid}, {31'd0, dv});
    checkOutput({tag, ".d_err"}, {31'd0, d_err}, {31'd0, de});
    checkOutput({tag, ".d_rdata"}, d_rdata, drd);
  endtask

  initial begin
    resetb = 1'b0;
    i_req  = 1'b0;
    i_addr = 32'd0;
    d_req  = 1'b0;
    d_addr = 32'd0;

    // Reset: grants forced low even with requests present
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h20);
    expGnt("rst", 1'b0, 1'b0, 9'd0);
    tickAndRsp("rst", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    resetb = 1'b1;

    // Single fetch to byte 0x10 -> word 4
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0);
    expGnt("ifetch", 1'b1, 1'b0, 9'd4);
    tickAndRsp("ifetch", 1'b1, 32'hC0DE0004, 1'b0, 1'b0, 32'd0);

    // Data load of the last ROM word
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h7FC);
    expGnt("dlast", 1'b0, 1'b1, 9'd511);
    tickAndRsp("dlast", 1'b0, 32'd0, 1'b1, 1'b0, 32'hC0DE01FF);

    // Contention: D,D,D,I,D,D,D,I with I at word 8, D at word 16
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 32'h20, 1'b1, 32'h40);
      if (c == 3 || c == 7) begin
        expGnt($sformatf("arb%0d", c), 1'b1, 1'b0, 9'd8);
        tickAndRsp($sformatf("arb%0d", c), 1'b1, 32'hC0DE0008, 1'b0, 1'b0, 32'd0);
      end else begin
        expGnt($sformatf("arb%0d", c), 1'b0, 1'b1, 9'd16);
        tickAndRsp($sformatf("arb%0d", c), 1'b0, 32'd0, 1'b1, 1'b0, 32'hC0DE0010);
      end
    end

    // Misaligned D alongside a fetch to word 3
    applyStimulus(1'b1, 32'h0C, 1'b1, 32'h802);
    expGnt("misal", 1'b1, 1'b1, 9'd3);
    tickAndRsp("misal", 1'b1, 32'hC0DE0003, 1'b1, 1'b1, 32'd0);

    // Out-of-range D alongside a fetch to word 5
    applyStimulus(1'b1, 32'h14, 1'b1, 32'h800);
    expGnt("oor", 1'b1, 1'b1, 9'd5);
    tickAndRsp("oor", 1'b1, 32'hC0DE0005, 1'b1, 1'b1, 32'd0);

    // Build streak to 3, then the I grant is interrupted by reset
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 32'h18, 1'b1, 32'h40);
      expGnt($sformatf("pre%0d", c), 1'b0, 1'b1, 9'd16);
      tickAndRsp($sformatf("pre%0d", c), 1'b0, 32'd0, 1'b1, 1'b0, 32'hC0DE0010);
    end
    applyStimulus(1'b1, 32'h18, 1'b1, 32'h40);
    expGnt("preI", 1'b1, 1'b0, 9'd6);
    #1;
    resetb = 1'b0;
    #1;
    expGnt("inrst", 1'b0, 1'b0, 9'd0);
    checkOutput("inrst.d_rvalid", {31'd0, d_rvalid}, 32'd0);
    tickAndRsp("inrst0", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tickAndRsp("inrst1", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    // Release with both requesting: a cleared streak lets D win three times
    @(negedge clk);
    resetb = 1'b1;
    #1;
    checkOutput("rel.i_rvalid", {31'd0, i_rvalid}, 32'd0);
    checkOutput("rel.d_rvalid", {31'd0, d_rvalid}, 32'd0);
    expGnt("rel0", 1'b0, 1'b1, 9'd16);
    tickAndRsp("rel0", 1'b0, 32'd0, 1'b1, 1'b0, 32'hC0DE0010);
    for (int c = 1; c < 4; c++) begin
      applyStimulus(1'b1, 32'h18, 1'b1, 32'h40);
      if (c == 3) begin
        expGnt("rel3", 1'b1, 1'b0, 9'd6);
        tickAndRsp("rel3", 1'b1, 32'hC0DE0006, 1'b0, 1'b0, 32'd0);
      end else begin
        expGnt($sformatf("rel%0d", c), 1'b0, 1'b1, 9'd16);
        tickAndRsp($sformatf("rel%0d", c), 1'b0, 32'd0, 1'b1, 1'b0, 32'hC0DE0010);
      end
    end

    // D grant to word 37, then idle: rom_addr holds
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h94);
    expGnt("d37", 1'b0, 1'b1, 9'd37);
    tickAndRsp("d37", 1'b0, 32'd0, 1'b1, 1'b0, 32'hC0DE0025);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
      expGnt($sformatf("idle%0d", c), 1'b0, 1'b0, 9'd37);
      tickAndRsp($sformatf("idle%0d", c), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    end

    // Next grant moves rom_addr; a high fetch address wraps modulo the ROM
    applyStimulus(1'b1, 32'hFFFF_F80B, 1'b0, 32'h0);
    expGnt("iwrap", 1'b1, 1'b0, 9'd2);
    tickAndRsp("iwrap", 1'b1, 32'hC0DE0002, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    expGnt("hold2", 1'b0, 1'b0, 9'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port, synchronous-read instruction ROM between two requesters: the pipeline's instruction-fetch port (I) and a data-load port (D) used for constant/rodata loads.
- Arbitrates each cycle and drives the ROM word address.
- Returns read data with the ROM's fixed 1-cycle latency.
- Sits between the fetch/memory stages and the ROM instance.

Parameters:
DEPTH, 512, ROM depth in words
DEPTH_LOG, 9, log2(DEPTH); width of ROM address
WIDTH, 32, ROM word width in bits
MAX_D_STREAK, 3, max consecutive D grants while I waits (>=1)

Ports:
clk  in  1  clock, all state on rising edge
resetb  in  1  asynchronous active-low reset
i_req  in  1  fetch read request
i_addr  in  32  fetch byte address
i_gnt  out  1  fetch request accepted this cycle (combinational)
i_rvalid  out  1  fetch data valid
i_rdata  out  WIDTH  fetch data
d_req  in  1  data read request
d_addr  in  32  data byte address
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  data response valid
d_rdata  out  WIDTH  data word
d_err  out  1  data response is an error, qualified by d_rvalid
rom_addr  out  DEPTH_LOG  ROM word address (combinational)
rom_rdata  in  WIDTH  ROM read data, 1 cycle after rom_addr

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, resetb). While resetb=0:
  - i_rvalid=0, d_rvalid=0, d_err=0.
  - i_gnt=0, d_gnt=0 (forced).
  - streak counter=0, last address register=0, rom_addr=0.
- Reset asserted with a read in flight: the response is dropped; no rvalid after reset release.
- Word address: word index = addr[DEPTH_LOG+1:2].
- Fetch: i_addr[31:DEPTH_LOG+2] and i_addr[1:0] are ignored, so fetch addresses wrap modulo the ROM.
- D bad address: d_addr is bad if d_addr[1:0]!=0 or d_addr[31:DEPTH_LOG+2]!=0.
  - A bad D request does not use the ROM and is granted in the cycle it is presented (d_gnt=1), independent of I.
  - In the next cycle: d_rvalid=1, d_err=1, d_rdata=0.
  - A bad request does not change the streak counter.
- Arbitration, good requests only:
  - Only I requests: I granted.
  - Only D requests: D granted.
  - Both request: D granted unless streak==MAX_D_STREAK, in which case I is granted.
- Streak counter:
  - Increments on a D grant while i_req=1 and I is not granted.
  - Clears to 0 on any I grant or any cycle with i_req=0.
  - Saturates at MAX_D_STREAK.
- rom_addr:
  - Equals the granted port's word index in a grant cycle.
  - Otherwise holds the last granted word index (register updated on every good grant).
- Response timing: a grant in cycle N gives <port>_rvalid=1 in cycle N+1 for exactly 1 cycle, with <port>_rdata=rom_rdata.
- rvalid and rdata are registered state / passthrough as follows:
  - A valid flag and an error flag are registered per port.
  - rdata = rom_rdata while rvalid and not err, else 0.
- Throughput:
  - One good grant per cycle in total.
  - A bad D grant and a good I grant may occur in the same cycle.
  - Back-to-back grants give back-to-back rvalids.
- Requesters need no backpressure: responses are always accepted. A requester holds req/addr until gnt is seen.

Test Plan:
- Reset, then i_req=1 with i_addr=0x10 for 1 cycle → i_gnt=1, rom_addr=4; next cycle i_rvalid=1, i_rdata=ROM[4]; d_rvalid stays 0.
- d_req=1 with d_addr=0x7FC → d_gnt=1, rom_addr=511; next cycle d_rvalid=1, d_err=0, d_rdata=ROM[511].
- i_req and d_req held high for 8 cycles with MAX_D_STREAK=3 → grant sequence D,D,D,I,D,D,D,I; rvalids follow one cycle later with matching data.
- d_addr=0x802 (misaligned), then d_addr=0x800 (out of range), each with i_req=1 → each cycle gives d_gnt=1 and i_gnt=1; next cycle d_err=1, d_rdata=0, and i_rdata is correct.
- Grant I at cycle N, drop resetb at N+0.5 for 2 cycles → no i_rvalid; after release all outputs are 0 and streak=0.
- Idle after a D grant to word 37 → rom_addr stays 37 with no rvalid, until the next grant.
